// File: rtl/data_memory_access_if.sv
// Data-bus interface between the memory-stage load/store unit (master)
// and the data memory / bus fabric (slave). Single outstanding transaction,
// request/grant handshake followed by one response beat.
interface data_memory_access_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     busRequest;
    logic                     busWrite;
    logic [ADDRESS_WIDTH-1:0] busAddress;
    logic [DATA_WIDTH-1:0]    busWriteData;
    logic [3:0]               busByteEnable;
    logic                     busGrant;
    logic                     busResponseValid;
    logic [DATA_WIDTH-1:0]    busReadData;
    logic                     busResponseError;

    modport master (
        output busRequest, busWrite, busAddress, busWriteData, busByteEnable,
        input  busGrant, busResponseValid, busReadData, busResponseError
    );

    modport slave (
        input  busRequest, busWrite, busAddress, busWriteData, busByteEnable,
        output busGrant, busResponseValid, busReadData, busResponseError
    );
endinterface

// File: rtl/data_memory_access.sv
// Memory-stage load/store unit. Converts one pipeline memory access into a
// single outstanding bus transaction, stalls the pipeline while it is in
// flight, returns extended load data, and flags misalignment, bus errors and
// response timeouts. Data path is fixed at 4 byte lanes.
module data_memory_access #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     requestValid,
    input  logic                     requestWrite,
    input  logic [1:0]               requestSize,
    input  logic                     requestUnsigned,
    input  logic [ADDRESS_WIDTH-1:0] requestAddress,
    input  logic [DATA_WIDTH-1:0]    requestWriteData,
    input  logic                     flush,
    output logic                     stallControl,
    output logic                     loadDataValid,
    output logic [DATA_WIDTH-1:0]    loadData,
    output logic                     misaligned,
    output logic                     busError,
    data_memory_access_if.master     bus
);

    // Counter holds 0 .. TIMEOUT_CYCLES-1; reaching the last value with no
    // response is the timeout.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         counter_q, counter_d;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic                     unsigned_q, unsigned_d;
    logic [1:0]               lane_q, lane_d;
    logic                     drain_next_q, drain_next_d;
    logic                     bus_request_q, bus_request_d;
    logic [ADDRESS_WIDTH-1:0] bus_address_q, bus_address_d;
    logic [DATA_WIDTH-1:0]    bus_write_data_q, bus_write_data_d;
    logic [3:0]               bus_byte_enable_q, bus_byte_enable_d;
    logic [DATA_WIDTH-1:0]    load_data_q, load_data_d;
    logic                     load_data_valid_q, load_data_valid_d;
    logic                     bus_error_q, bus_error_d;
    logic                     stall_s;
    logic                     misaligned_s;

    // Access is illegal when the address is not naturally aligned or size is 3.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            2'd2:    return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an aligned access.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    return 4'b0001 << lane;
            2'd1:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the slave can pick any lane.
    function automatic logic [DATA_WIDTH-1:0] lane_replicate(input logic [1:0] size,
                                                             input logic [DATA_WIDTH-1:0] wd);
        case (size)
            2'd0:    return {(DATA_WIDTH/8){wd[7:0]}};
            2'd1:    return {(DATA_WIDTH/16){wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Select the addressed bytes from the read word and sign/zero extend.
    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] rdata,
                                                           input logic [1:0] size,
                                                           input logic [1:0] lane,
                                                           input logic       is_unsigned);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = rdata >> {lane, 3'b000};
        case (size)
            2'd0:    return {{(DATA_WIDTH-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
            2'd1:    return {{(DATA_WIDTH-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    // Next-state, capture and output decode for the access sequencer.
    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        write_d           = write_q;
        size_d            = size_q;
        unsigned_d        = unsigned_q;
        lane_d            = lane_q;
        drain_next_d      = drain_next_q;
        bus_request_d     = 1'b0;
        bus_address_d     = bus_address_q;
        bus_write_data_d  = bus_write_data_q;
        bus_byte_enable_d = bus_byte_enable_q;
        load_data_d       = load_data_q;
        load_data_valid_d = 1'b0;
        bus_error_d       = 1'b0;
        stall_s           = 1'b0;
        misaligned_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (requestValid && !flush) begin
                    if (is_misaligned(requestSize, requestAddress[1:0])) begin
                        misaligned_s = 1'b1;
                    end else begin
                        stall_s           = 1'b1;
                        write_d           = requestWrite;
                        size_d            = requestSize;
                        unsigned_d        = requestUnsigned;
                        lane_d            = requestAddress[1:0];
                        bus_address_d     = {requestAddress[ADDRESS_WIDTH-1:2], 2'b00};
                        bus_byte_enable_d = lane_enable(requestSize, requestAddress[1:0]);
                        bus_write_data_d  = requestWrite ? lane_replicate(requestSize, requestWriteData)
                                                         : {DATA_WIDTH{1'b0}};
                        bus_request_d     = 1'b1;
                        state_d           = ST_REQUEST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQUEST: begin
                stall_s = 1'b1;
                if (flush) begin
                    // A grant in the flush cycle means the access is already
                    // on the bus, so its response still has to be absorbed.
                    counter_d = {CNT_W{1'b0}};
                    state_d   = bus.busGrant ? ST_DRAIN : ST_IDLE;
                end else if (bus.busGrant) begin
                    counter_d = {CNT_W{1'b0}};
                    state_d   = ST_WAIT;
                end else begin
                    bus_request_d = 1'b1;
                end
            end

            ST_WAIT: begin
                stall_s   = 1'b1;
                counter_d = counter_q + CNT_ONE;
                if (flush) begin
                    // A response arriving with the flush is consumed on the
                    // spot; otherwise it is still in flight and gets drained.
                    counter_d = {CNT_W{1'b0}};
                    state_d   = bus.busResponseValid ? ST_IDLE : ST_DRAIN;
                end else if (bus.busResponseValid) begin
                    state_d      = ST_DONE;
                    drain_next_d = 1'b0;
                    if (bus.busResponseError) begin
                        bus_error_d = 1'b1;
                    end else if (!write_q) begin
                        load_data_valid_d = 1'b1;
                        load_data_d       = extract_load(bus.busReadData, size_q, lane_q, unsigned_q);
                    end else begin
                        load_data_valid_d = 1'b0;
                    end
                end else if (counter_q == TIMEOUT_LAST) begin
                    state_d      = ST_DONE;
                    bus_error_d  = 1'b1;
                    drain_next_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                counter_d    = {CNT_W{1'b0}};
                drain_next_d = 1'b0;
                state_d      = drain_next_q ? ST_DRAIN : ST_IDLE;
            end

            ST_DRAIN: begin
                stall_s   = requestValid;
                counter_d = counter_q + CNT_ONE;
                if (bus.busResponseValid || (counter_q == TIMEOUT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs; synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            counter_q         <= {CNT_W{1'b0}};
            write_q           <= 1'b0;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            lane_q            <= 2'b00;
            drain_next_q      <= 1'b0;
            bus_request_q     <= 1'b0;
            bus_address_q     <= {ADDRESS_WIDTH{1'b0}};
            bus_write_data_q  <= {DATA_WIDTH{1'b0}};
            bus_byte_enable_q <= 4'b0000;
            load_data_q       <= {DATA_WIDTH{1'b0}};
            load_data_valid_q <= 1'b0;
            bus_error_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            counter_q         <= counter_d;
            write_q           <= write_d;
            size_q            <= size_d;
            unsigned_q        <= unsigned_d;
            lane_q            <= lane_d;
            drain_next_q      <= drain_next_d;
            bus_request_q     <= bus_request_d;
            bus_address_q     <= bus_address_d;
            bus_write_data_q  <= bus_write_data_d;
            bus_byte_enable_q <= bus_byte_enable_d;
            load_data_q       <= load_data_d;
            load_data_valid_q <= load_data_valid_d;
            bus_error_q       <= bus_error_d;
        end
    end

    assign stallControl      = stall_s;
    assign misaligned        = misaligned_s;
    assign loadDataValid     = load_data_valid_q;
    assign loadData          = load_data_q;
    assign busError          = bus_error_q;
    assign bus.busRequest    = bus_request_q;
    assign bus.busWrite      = write_q;
    assign bus.busAddress    = bus_address_q;
    assign bus.busWriteData  = bus_write_data_q;
    assign bus.busByteEnable = bus_byte_enable_q;

endmodule

// File: tb/tb_data_memory_access.sv
// Self-checking bench for data_memory_access: reset state, a table of
// directed accesses, misalignment cases, hand sequences for flush/drain,
// timeout and reset corners, and randomized accesses checked against a
// byte-level reference model.
module tb_data_memory_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        requestValid, requestWrite, requestUnsigned, flush;
    logic [1:0]  requestSize;
    logic [31:0] requestAddress, requestWriteData;
    logic        stallControl, loadDataValid, misaligned, busError;
    logic [31:0] loadData;

    int tests = 0;
    int fails = 0;

    data_memory_access_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    data_memory_access #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .requestValid(requestValid), .requestWrite(requestWrite),
        .requestSize(requestSize), .requestUnsigned(requestUnsigned),
        .requestAddress(requestAddress), .requestWriteData(requestWriteData),
        .flush(flush), .stallControl(stallControl), .loadDataValid(loadDataValid),
        .loadData(loadData), .misaligned(misaligned), .busError(busError),
        .bus(bus_if.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-level view of the rules) ----------
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
        int n = 1 << sz;
        int lane = int'(addr % 4);
        logic [3:0] be = 4'b0000;
        for (int k = 0; k < n; k++) be[lane + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic wr, input logic [1:0] sz, input logic [31:0] wdata);
        int n = 1 << sz;
        logic [31:0] out = 32'h0;
        if (wr) for (int b = 0; b < 4; b++) out[8*b +: 8] = wdata[8*(b % n) +: 8];
        return out;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
        int n = 1 << sz;
        int lane = int'(addr % 4);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(lane + k) +: 8];
        if (!uns && n < 4 && v[8*n - 1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- one complete access with checks -------------------------
    task automatic do_access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input int gd, input int rd,
                             input logic [31:0] rdata, input logic rerr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        int stalls = 0;
        @(negedge clock);
        requestValid = 1'b1; requestWrite = wr; requestSize = sz; requestUnsigned = uns;
        requestAddress = addr; requestWriteData = wdata; flush = 1'b0;
        #1;
        check({tag, " idle_stall"}, stallControl, 1'b1);
        check({tag, " idle_misaligned"}, misaligned, 1'b0);
        stalls += int'(stallControl);
        for (int i = 0; i <= gd; i++) begin
            @(negedge clock);
            bus_if.busGrant = (i == gd);
            requestAddress = ~addr; requestWriteData = ~wdata;   // bus must use captured fields
            #1;
            check({tag, " req"}, bus_if.busRequest, 1'b1);
            check({tag, " addr"}, bus_if.busAddress, addr & 32'hFFFF_FFFC);
            check({tag, " be"}, bus_if.busByteEnable, exp_be);
            check({tag, " wdata"}, bus_if.busWriteData, exp_wd);
            check({tag, " wr"}, bus_if.busWrite, wr);
            stalls += int'(stallControl);
        end
        for (int j = 0; j <= rd; j++) begin
            @(negedge clock);
            bus_if.busGrant = 1'b0;
            bus_if.busResponseValid = (j == rd);
            bus_if.busResponseError = rerr && (j == rd);
            bus_if.busReadData = (j == rd) ? rdata : 32'h0;
            #1;
            check({tag, " wait_req"}, bus_if.busRequest, 1'b0);
            stalls += int'(stallControl);
        end
        @(negedge clock);
        bus_if.busResponseValid = 1'b0; bus_if.busResponseError = 1'b0;
        #1;
        check({tag, " done_stall"}, stallControl, 1'b0);
        check({tag, " done_ldv"}, loadDataValid, !wr && !rerr);
        check({tag, " done_err"}, busError, rerr);
        if (!wr && !rerr) check({tag, " load_data"}, loadData, exp_ld);
        check({tag, " stall_cycles"}, stalls, gd + rd + 3);
        @(negedge clock);
        requestValid = 1'b0;
        #1;
        check({tag, " after_ldv"}, loadDataValid, 1'b0);
        check({tag, " after_err"}, busError, 1'b0);
        check({tag, " after_req"}, bus_if.busRequest, 1'b0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic        rerr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr;
        logic        fl;
        logic        mis;
    } mis_t;

    vec_t vecs[10];
    mis_t mvecs[6];

    initial begin
        vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 4'hF,    32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h8012_3456, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 0, 0, 32'h8012_3456, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3] = '{1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_ABCD, 1, 0, 32'h0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 0, 2, 32'h8001_1234, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[5] = '{1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_005A, 0, 0, 32'h0, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        vecs[6] = '{1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678, 3, 1, 32'h0, 1'b0, 4'hF,    32'h1234_5678, 32'h0};
        vecs[7] = '{1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1, 4'hF,    32'h0,         32'h0};
        vecs[8] = '{1'b0, 2'd1, 1'b1, 32'h0000_6000, 32'h0, 2, 3, 32'h1234_F00D, 1'b0, 4'b0011, 32'h0,         32'h0000_F00D};
        vecs[9] = '{1'b0, 2'd0, 1'b0, 32'h0000_7001, 32'h0, 0, 0, 32'h1234_7F00, 1'b0, 4'b0010, 32'h0,         32'h0000_007F};

        mvecs[0] = '{2'd2, 32'h0000_1001, 1'b0, 1'b1};
        mvecs[1] = '{2'd2, 32'h0000_1002, 1'b0, 1'b1};
        mvecs[2] = '{2'd1, 32'h0000_1001, 1'b0, 1'b1};
        mvecs[3] = '{2'd1, 32'h0000_1003, 1'b0, 1'b1};
        mvecs[4] = '{2'd3, 32'h0000_1000, 1'b0, 1'b1};
        mvecs[5] = '{2'd2, 32'h0000_1001, 1'b1, 1'b0};

        reset = 1'b1;
        requestValid = 1'b0; requestWrite = 1'b0; requestSize = 2'd0; requestUnsigned = 1'b0;
        requestAddress = 32'h0; requestWriteData = 32'h0; flush = 1'b0;
        bus_if.busGrant = 1'b0; bus_if.busResponseValid = 1'b0;
        bus_if.busReadData = 32'h0; bus_if.busResponseError = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst loadData", loadData, 32'h0);
        check("rst loadDataValid", loadDataValid, 1'b0);
        check("rst busError", busError, 1'b0);
        check("rst busRequest", bus_if.busRequest, 1'b0);
        check("rst busWrite", bus_if.busWrite, 1'b0);
        check("rst busAddress", bus_if.busAddress, 32'h0);
        check("rst busWriteData", bus_if.busWriteData, 32'h0);
        check("rst busByteEnable", bus_if.busByteEnable, 4'h0);
        check("rst stall", stallControl, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Directed table
        for (int v = 0; v < 10; v++)
            do_access($sformatf("vec%0d", v), vecs[v].wr, vecs[v].sz, vecs[v].uns, vecs[v].addr,
                      vecs[v].wdata, vecs[v].gd, vecs[v].rd, vecs[v].rdata, vecs[v].rerr,
                      vecs[v].be, vecs[v].wd, vecs[v].ld);

        // Misalignment table
        for (int m = 0; m < 6; m++) begin
            @(negedge clock);
            requestValid = 1'b1; requestWrite = 1'b0; requestSize = mvecs[m].sz;
            requestAddress = mvecs[m].addr; flush = mvecs[m].fl;
            #1;
            check($sformatf("mis%0d flag", m), misaligned, mvecs[m].mis);
            check($sformatf("mis%0d stall", m), stallControl, 1'b0);
            @(negedge clock);
            requestValid = 1'b0; flush = 1'b0;
            #1;
            check($sformatf("mis%0d no_req", m), bus_if.busRequest, 1'b0);
        end

        // Flush in WAIT, response 3 cycles later, new request held meanwhile
        @(negedge clock);
        requestValid = 1'b1; requestWrite = 1'b0; requestSize = 2'd2; requestAddress = 32'h1000;
        @(negedge clock);
        bus_if.busGrant = 1'b1;
        @(negedge clock);
        bus_if.busGrant = 1'b0; requestValid = 1'b0; flush = 1'b1;
        #1; check("fl wait_stall", stallControl, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            flush = 1'b0; requestValid = 1'b1; requestAddress = 32'h2000;
            #1;
            check("fl drain_stall", stallControl, 1'b1);
            check("fl drain_req", bus_if.busRequest, 1'b0);
        end
        @(negedge clock);
        bus_if.busResponseValid = 1'b1; bus_if.busReadData = 32'h1111_1111;
        #1; check("fl resp_stall", stallControl, 1'b1);
        @(negedge clock);
        bus_if.busResponseValid = 1'b0;
        #1;
        check("fl no_ldv", loadDataValid, 1'b0);
        check("fl no_err", busError, 1'b0);
        check("fl idle_accept", stallControl, 1'b1);
        check("fl idle_req", bus_if.busRequest, 1'b0);
        @(negedge clock);
        bus_if.busGrant = 1'b1;
        #1;
        check("fl new_req", bus_if.busRequest, 1'b1);
        check("fl new_addr", bus_if.busAddress, 32'h2000);
        @(negedge clock);
        bus_if.busGrant = 1'b0; bus_if.busResponseValid = 1'b1; bus_if.busReadData = 32'hCAFE_F00D;
        @(negedge clock);
        bus_if.busResponseValid = 1'b0;
        #1;
        check("fl new_ldv", loadDataValid, 1'b1);
        check("fl new_data", loadData, 32'hCAFE_F00D);
        @(negedge clock);
        requestValid = 1'b0;

        // Timeout (4 WAIT cycles), DRAIN, late error response is silent
        @(negedge clock);
        requestValid = 1'b1; requestAddress = 32'h7000;
        @(negedge clock);
        bus_if.busGrant = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            bus_if.busGrant = 1'b0;
            #1;
            check("to wait_err", busError, 1'b0);
            check("to wait_stall", stallControl, 1'b1);
        end
        @(negedge clock);
        #1;
        check("to err_pulse", busError, 1'b1);
        check("to ldv", loadDataValid, 1'b0);
        check("to done_stall", stallControl, 1'b0);
        @(negedge clock);
        requestValid = 1'b0;
        #1;
        check("to drain_err", busError, 1'b0);
        check("to drain_stall0", stallControl, 1'b0);
        @(negedge clock);
        requestValid = 1'b1; requestAddress = 32'h7100;
        #1;
        check("to drain_stall1", stallControl, 1'b1);
        check("to drain_req", bus_if.busRequest, 1'b0);
        @(negedge clock);
        bus_if.busResponseValid = 1'b1; bus_if.busResponseError = 1'b1;
        #1; check("to late_err_now", busError, 1'b0);
        @(negedge clock);
        bus_if.busResponseValid = 1'b0; bus_if.busResponseError = 1'b0;
        #1;
        check("to late_err_after", busError, 1'b0);
        check("to idle_accept", stallControl, 1'b1);
        @(negedge clock);
        bus_if.busGrant = 1'b1;
        #1;
        check("to new_req", bus_if.busRequest, 1'b1);
        check("to new_addr", bus_if.busAddress, 32'h7100);
        @(negedge clock);
        bus_if.busGrant = 1'b0; bus_if.busResponseValid = 1'b1; bus_if.busReadData = 32'h0BAD_CAFE;
        @(negedge clock);
        bus_if.busResponseValid = 1'b0;
        #1; check("to new_ldv", loadDataValid, 1'b1);
        @(negedge clock);
        requestValid = 1'b0;

        // Flush before grant: request withdrawn, nothing issued
        @(negedge clock);
        requestValid = 1'b1; requestAddress = 32'h8000;
        @(negedge clock);
        flush = 1'b1; requestValid = 1'b0;
        #1; check("fg req_cycle", bus_if.busRequest, 1'b1);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("fg withdrawn", bus_if.busRequest, 1'b0);
        check("fg stall", stallControl, 1'b0);
        @(negedge clock);
        #1; check("fg no_ldv", loadDataValid, 1'b0);

        // Flush in WAIT with no response: DRAIN times out silently
        @(negedge clock);
        requestValid = 1'b1; requestAddress = 32'h9000;
        @(negedge clock);
        bus_if.busGrant = 1'b1;
        @(negedge clock);
        bus_if.busGrant = 1'b0; flush = 1'b1; requestValid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            flush = 1'b0; requestValid = 1'b1; requestAddress = 32'h9100;
            #1;
            check("dt drain_stall", stallControl, 1'b1);
            check("dt drain_err", busError, 1'b0);
        end
        @(negedge clock);
        #1;
        check("dt idle_accept", stallControl, 1'b1);
        check("dt no_err", busError, 1'b0);
        @(negedge clock);
        requestValid = 1'b0;
        #1; check("dt new_addr", bus_if.busAddress, 32'h9100);

        // Reset mid-transaction: everything abandoned
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mr busRequest", bus_if.busRequest, 1'b0);
        check("mr stall", stallControl, 1'b0);
        check("mr loadData", loadData, 32'h0);
        check("mr busAddress", bus_if.busAddress, 32'h0);
        reset = 1'b0;

        // Randomized accesses against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [1:0]  sz;
            logic [31:0] addr, wdata, rdata, rnd;
            logic        wr, uns, rerr;
            sz    = 2'($urandom_range(0, 2));
            rnd   = $urandom;
            addr  = {rnd[31:2], 2'b00} | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            wdata = $urandom;
            rdata = $urandom;
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            rerr  = ($urandom_range(0, 7) == 0);
            do_access($sformatf("rnd%0d", r), wr, sz, uns, addr, wdata,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdata, rerr,
                      m_be(sz, addr), m_wd(wr, sz, wdata), m_ld(sz, uns, addr, rdata));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_access.md
Name: data_memory_access

Overview:
- Memory-stage load/store unit that turns an execute/memory-stage access into a single-outstanding data-bus transaction.
- Produces the stall and load-data-valid signals that the pipeline hazard controller consumes: stallControl while an access is pending, loadDataValid when load data returns.
- Detects misaligned accesses, bus errors and response timeouts, and reports them for trap handling.

Parameters:
- ADDRESS_WIDTH, 32, request/bus address width.
- DATA_WIDTH, 32, data width; fixed 4 byte lanes.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a forced bus error (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- requestValid  in  1  memory op present in execute/memory stage.
- requestWrite  in  1  1 = store, 0 = load.
- requestSize  in  2  0 byte, 1 half, 2 word, 3 illegal.
- requestUnsigned  in  1  zero-extend load (else sign-extend).
- requestAddress  in  ADDRESS_WIDTH  byte address.
- requestWriteData  in  DATA_WIDTH  store data, LSB-aligned.
- flush  in  1  kill current instruction (trap/redirect flush).
- stallControl  out  1  hold pipeline.
- loadDataValid  out  1  one-cycle pulse, load result valid.
- loadData  out  DATA_WIDTH  extended load result.
- misaligned  out  1  misaligned/illegal-size access.
- busError  out  1  one-cycle pulse, bus error or timeout.
- busRequest  out  1  bus request valid.
- busWrite  out  1  bus write.
- busAddress  out  ADDRESS_WIDTH  word-aligned address, low 2 bits 0.
- busWriteData  out  DATA_WIDTH  lane-replicated store data.
- busByteEnable  out  4  active byte lanes.
- busGrant  in  1  bus accepts the request this cycle.
- busResponseValid  in  1  response this cycle.
- busReadData  in  DATA_WIDTH  full read word.
- busResponseError  in  1  response carries an error.

Behaviour:
- States: IDLE, REQUEST, WAIT, DONE, DRAIN. Reset → IDLE.
- Reset values:
  - All registered outputs 0: loadData, loadDataValid, busError.
  - All bus outputs 0.
  - Timeout counter 0.
- Reset mid-operation: abandon any transaction; the bus is reset simultaneously.
- Misalignment (combinational, IDLE only; misaligned = requestValid && !flush && condition):
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - size 3.
  - Effect: no bus access, no stall, state stays IDLE.
- IDLE:
  - requestValid && !flush && aligned: stallControl = 1 combinationally in the same cycle.
  - Capture request fields into registers; go to REQUEST.
- REQUEST:
  - busRequest = 1, with address/data/enables driven from the captured registers and held stable until grant.
  - stallControl = 1.
  - busGrant → WAIT; counter cleared.
  - flush before grant → IDLE, request withdrawn, nothing issued.
- WAIT:
  - stallControl = 1; counter increments each cycle.
  - busResponseValid:
    - lane = addr[1:0]; shift busReadData right by 8·lane.
    - Byte: take 8 bits; half: take 16 bits; extend per requestUnsigned.
    - Register into loadData; go to DONE.
  - busResponseError → DONE, busError pending.
  - counter reaching TIMEOUT_CYCLES with no response → DONE, busError pending, and DRAIN follows DONE.
  - flush → DRAIN (in-flight response must be absorbed).
- DONE (exactly one cycle):
  - stallControl = 0, so the pipeline advances.
  - loadDataValid = 1 for a successful load only; stores and errors give 0.
  - busError = 1 if an error is pending.
  - New requests are ignored this cycle; next state IDLE, or DRAIN after a timeout.
- DRAIN:
  - Wait for busResponseValid, discard the data, no pulses, then → IDLE.
  - stallControl = requestValid (new accesses held until the bus is free).
  - The timeout counter also applies here: on expiry → IDLE silently.
- Stores:
  - byte: enable 1<<lane, data replicated 4×.
  - half: enable 3<<lane, data replicated 2×.
  - word: enable 4'hF.
- Loads:
  - busByteEnable as for stores; busWriteData = 0.
- Simultaneous events:
  - flush has priority over response in WAIT.
  - Response and timeout in the same cycle: the response wins.
- Only one transaction outstanding; no new bus request until IDLE.

Test Plan:
- Word load at 0x0000_1000; grant after 1 cycle; response 2 cycles later with data 0xDEAD_BEEF → stallControl high 4 cycles; DONE: loadDataValid = 1, loadData = 0xDEAD_BEEF; busByteEnable = 4'hF.
- Signed byte load at 0x1003, busReadData 0x80xx_xxxx → loadData 0xFFFF_FF80; unsigned → 0x0000_0080; busAddress 0x1000.
- Half store at 0x1002, data 0x0000_ABCD → busByteEnable 4'b1100, busWriteData 0xABCD_ABCD; DONE: loadDataValid = 0.
- Word load at 0x1001 → misaligned = 1 same cycle; busRequest stays 0; stallControl = 0.
- flush in WAIT, then response 3 cycles later with a new requestValid held → no loadDataValid; stallControl high until drained; the new request is issued afterwards.
- TIMEOUT_CYCLES = 4, no response → busError pulse 4 cycles after grant, then DRAIN; late error response → busError remains 0.
